// File: rtl/ahb_resp_mux.sv
// AHB-Lite response multiplexer: registers the decoder select at address-phase
// acceptance and routes the selected slave's response, with a built-in default slave.
module ahb_resp_mux #(
  parameter int NSLV = 4,
  parameter int DW   = 32
) (
  input  logic               hclk,
  input  logic               hresetn,
  input  logic [1:0]         htrans,
  input  logic [NSLV-1:0]    hsel_addr,
  input  logic [NSLV*DW-1:0] hrdata_s,
  input  logic [NSLV-1:0]    hreadyout_s,
  input  logic [NSLV-1:0]    hresp_s,
  output logic [DW-1:0]      hrdata,
  output logic               hready,
  output logic               hresp,
  output logic [NSLV-1:0]    dsel,
  output logic               sel_err
);

  typedef enum logic [1:0] {S_IDLE, S_ERR1, S_ERR2} ds_state_e;

  ds_state_e                 state_q, state_d;
  logic [NSLV-1:0]           dsel_q, dsel_d;
  logic                      sel_err_q, sel_err_d;
  logic [NSLV-1:0]           sel_low;
  logic                      multi_hot;
  logic [NSLV-1:0][DW-1:0]   rd_mask;
  logic [DW-1:0]             rd_or;
  logic                      unused_htrans0;

  // Only htrans[1] distinguishes an active transfer; BUSY behaves like IDLE here.
  assign unused_htrans0 = htrans[0];

  assign sel_low   = hsel_addr & (~hsel_addr + NSLV'(1));
  assign multi_hot = |(hsel_addr & (hsel_addr - NSLV'(1)));

  for (genvar i = 0; i < NSLV; i++) begin : g_lane
    assign rd_mask[i] = hrdata_s[i*DW +: DW] & {DW{dsel_q[i]}};
  end

  always_comb begin
    rd_or = '0;
    for (int i = 0; i < NSLV; i++) rd_or = rd_or | rd_mask[i];
  end

  // dsel_q is one-hot or zero, so a plain AND-OR is sufficient.
  always_comb begin
    hrdata = '0;
    hready = 1'b1;
    hresp  = 1'b0;
    if (|dsel_q) begin
      hrdata = rd_or;
      hready = |(dsel_q & hreadyout_s);
      hresp  = |(dsel_q & hresp_s);
    end else begin
      case (state_q)
        S_ERR1: begin
          hready = 1'b0;
          hresp  = 1'b1;
        end
        S_ERR2: hresp = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    dsel_d    = dsel_q;
    sel_err_d = sel_err_q;
    if (state_q == S_ERR1) begin
      state_d = S_ERR2;
    end else if (hready) begin
      dsel_d    = sel_low;
      sel_err_d = sel_err_q | multi_hot;
      state_d   = (hsel_addr == '0 && htrans[1]) ? S_ERR1 : S_IDLE;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q   <= S_IDLE;
      dsel_q    <= '0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dsel_q    <= dsel_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign dsel    = dsel_q;
  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Scoreboard bench for ahb_resp_mux: stimulus queues expected per-cycle outputs,
// a negedge monitor pops and compares them.
module tb_ahb_resp_mux;
  localparam int NSLV = 4;
  localparam int DW   = 32;

  logic               hclk = 1'b0;
  logic               hresetn;
  logic [1:0]         htrans;
  logic [NSLV-1:0]    hsel_addr;
  logic [NSLV*DW-1:0] hrdata_s;
  logic [NSLV-1:0]    hreadyout_s;
  logic [NSLV-1:0]    hresp_s;
  logic [DW-1:0]      hrdata;
  logic               hready;
  logic               hresp;
  logic [NSLV-1:0]    dsel;
  logic               sel_err;

  ahb_resp_mux #(.NSLV(NSLV), .DW(DW)) dut (
    .hclk(hclk), .hresetn(hresetn), .htrans(htrans), .hsel_addr(hsel_addr),
    .hrdata_s(hrdata_s), .hreadyout_s(hreadyout_s), .hresp_s(hresp_s),
    .hrdata(hrdata), .hready(hready), .hresp(hresp), .dsel(dsel), .sel_err(sel_err)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    string       name;
    logic [31:0] d;
    logic        r;
    logic        e;
    logic [3:0]  s;
    logic        se;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  localparam logic [31:0] SD0 = 32'h1111_1111;
  localparam logic [31:0] SD1 = 32'h2222_2222;
  localparam logic [31:0] SD2 = 32'hDEAD_BEEF;
  localparam logic [31:0] SD3 = 32'h4444_4444;

  // Monitor: one expected entry per cycle, compared mid-cycle.
  always @(negedge hclk) begin
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      total++;
      if (hrdata !== x.d || hready !== x.r || hresp !== x.e || dsel !== x.s || sel_err !== x.se) begin
        bad++;
        $display("FAIL %s: got hrdata=%h hready=%b hresp=%b dsel=%b sel_err=%b want hrdata=%h hready=%b hresp=%b dsel=%b sel_err=%b",
                 x.name, hrdata, hready, hresp, dsel, sel_err, x.d, x.r, x.e, x.s, x.se);
      end
    end
  end

  task automatic expect_out(input string nm, input logic [31:0] d, input logic r,
                            input logic e, input logic [3:0] s, input logic se);
    exp_t x;
    x.name = nm; x.d = d; x.r = r; x.e = e; x.s = s; x.se = se;
    q.push_back(x);
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic addr(input logic [1:0] t, input logic [3:0] s);
    htrans    = t;
    hsel_addr = s;
  endtask

  logic [31:0] sd [4];

  initial begin
    sd[0] = SD0; sd[1] = SD1; sd[2] = SD2; sd[3] = SD3;
    hresetn     = 1'b0;
    htrans      = 2'b00;
    hsel_addr   = '0;
    hrdata_s    = {SD3, SD2, SD1, SD0};
    hreadyout_s = 4'hF;
    hresp_s     = 4'h0;
    #2;
    expect_out("reset_state", 32'h0, 1'b1, 1'b0, 4'b0000, 1'b0);
    @(negedge hclk);
    #1 hresetn = 1'b1;

    // Routing to every slave, back-to-back.
    addr(2'b10, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      step();
      expect_out($sformatf("route_s%0d", i), sd[i], 1'b1, 1'b0, 4'(1 << i), 1'b0);
      if (i < 3) addr(2'b10, 4'(1 << (i + 1)));
      else       addr(2'b00, 4'b0000);
    end
    step();
    expect_out("idle_after_route", 32'h0, 1'b1, 1'b0, 4'b0000, 1'b0);

    // Slave 1 wait states while the next select is already 1000.
    addr(2'b10, 4'b0010);
    step();
    hreadyout_s[1] = 1'b0;
    addr(2'b10, 4'b1000);
    expect_out("wait_1", SD1, 1'b0, 1'b0, 4'b0010, 1'b0);
    step();
    expect_out("wait_2", SD1, 1'b0, 1'b0, 4'b0010, 1'b0);
    step();
    expect_out("wait_3", SD1, 1'b0, 1'b0, 4'b0010, 1'b0);
    step();
    hreadyout_s[1] = 1'b1;
    expect_out("wait_done", SD1, 1'b1, 1'b0, 4'b0010, 1'b0);
    step();
    addr(2'b00, 4'b0000);
    expect_out("wait_next_s3", SD3, 1'b1, 1'b0, 4'b1000, 1'b0);
    step();
    expect_out("wait_idle", 32'h0, 1'b1, 1'b0, 4'b0000, 1'b0);

    // Default slave: back-to-back unmapped NONSEQs, then idle.
    addr(2'b10, 4'b0000);
    step();
    expect_out("dflt_err1_a", 32'h0, 1'b0, 1'b1, 4'b0000, 1'b0);
    step();
    expect_out("dflt_err2_a", 32'h0, 1'b1, 1'b1, 4'b0000, 1'b0);
    step();
    addr(2'b00, 4'b0000);
    expect_out("dflt_err1_b", 32'h0, 1'b0, 1'b1, 4'b0000, 1'b0);
    step();
    expect_out("dflt_err2_b", 32'h0, 1'b1, 1'b1, 4'b0000, 1'b0);
    step();
    expect_out("dflt_idle_okay", 32'h0, 1'b1, 1'b0, 4'b0000, 1'b0);
    step();
    expect_out("dflt_idle_okay2", 32'h0, 1'b1, 1'b0, 4'b0000, 1'b0);

    // Mapped transfer accepted in ERR2.
    addr(2'b10, 4'b0000);
    step();
    expect_out("err2map_err1", 32'h0, 1'b0, 1'b1, 4'b0000, 1'b0);
    step();
    addr(2'b10, 4'b0001);
    expect_out("err2map_err2", 32'h0, 1'b1, 1'b1, 4'b0000, 1'b0);
    step();
    addr(2'b00, 4'b0000);
    expect_out("err2map_s0", SD0, 1'b1, 1'b0, 4'b0001, 1'b0);
    step();

    // Slave 3 error passthrough with a wait state.
    addr(2'b10, 4'b1000);
    step();
    hresp_s[3]     = 1'b1;
    hreadyout_s[3] = 1'b0;
    addr(2'b00, 4'b0000);
    expect_out("s3_err_wait", SD3, 1'b0, 1'b1, 4'b1000, 1'b0);
    step();
    hreadyout_s[3] = 1'b1;
    expect_out("s3_err_done", SD3, 1'b1, 1'b1, 4'b1000, 1'b0);
    step();
    hresp_s[3] = 1'b0;
    expect_out("s3_err_after", 32'h0, 1'b1, 1'b0, 4'b0000, 1'b0);

    // Multi-hot select: lowest index wins, sticky error flag.
    addr(2'b10, 4'b0110);
    step();
    addr(2'b10, 4'b0100);
    expect_out("multihot_s1", SD1, 1'b1, 1'b0, 4'b0010, 1'b1);
    step();
    addr(2'b00, 4'b0000);
    expect_out("multihot_sticky_s2", SD2, 1'b1, 1'b0, 4'b0100, 1'b1);
    step();
    expect_out("multihot_sticky_idle", 32'h0, 1'b1, 1'b0, 4'b0000, 1'b1);

    // Asynchronous reset in the middle of ERR1.
    addr(2'b10, 4'b0000);
    step();
    addr(2'b00, 4'b0000);
    expect_out("pre_reset_err1", 32'h0, 1'b0, 1'b1, 4'b0000, 1'b1);
    @(negedge hclk);
    #1 hresetn = 1'b0;
    #1 expect_out("reset_mid_err1", 32'h0, 1'b1, 1'b0, 4'b0000, 1'b0);
    @(negedge hclk);
    #1 hresetn = 1'b1;
    step();

    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge hclk);
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain: pending=%0d want 0", q.size());
    end
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
